// File: rtl/mul_writeback_stage_pkg.sv
// Shared types for the multiplier writeback stage.
// Contents:
//   - mul_ops_e       RV32M multiply op select
//   - mul_wb_entry_t  one buffered writeback result (data + destination register)
//   - fifo_state_e    occupancy of the 2-entry result buffer
//   - MUL_WB_DEPTH    result buffer depth
// The entry struct is sized by MUL_WB_DATA_WIDTH / MUL_WB_RD_WIDTH. The stage
// parameters default to these values and must be kept equal to them.
package mul_writeback_stage_pkg;

  localparam int MUL_WB_DATA_WIDTH = 32;
  localparam int MUL_WB_RD_WIDTH   = 5;
  localparam int MUL_WB_DEPTH      = 2;

  typedef enum logic [1:0] {
    MUL_U    = 2'd0,
    MULH_U   = 2'd1,
    MULHSU_U = 2'd2,
    MULHU_U  = 2'd3
  } mul_ops_e;

  typedef struct packed {
    logic [MUL_WB_DATA_WIDTH-1:0] data;
    logic [MUL_WB_RD_WIDTH-1:0]   rd;
  } mul_wb_entry_t;

  // The encoding doubles as the entry count.
  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/mul_writeback_stage_result_format.sv
// mul_result_format: selects the architectural 32-bit result from the raw
// 2*W-bit product and applies the MULHSU correction. Purely combinational.
// Ports:
//   op        in   op select (MUL / MULH / MULHSU / MULHU)
//   prod      in   raw product, 2*DATA_WIDTH bits
//   op_a      in   rs1 value of the operation
//   op_b_msb  in   rs2 sign bit of the operation
//   data      out  formatted DATA_WIDTH-bit result
module mul_result_format
  import mul_writeback_stage_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_WB_DATA_WIDTH
) (
  input  mul_ops_e                  op,
  input  logic [2*DATA_WIDTH-1:0]   prod,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic                      op_b_msb,
  output logic [DATA_WIDTH-1:0]     data
);

  logic [DATA_WIDTH-1:0] prod_hi;
  logic [DATA_WIDTH-1:0] prod_lo;

  assign prod_hi = prod[2*DATA_WIDTH-1:DATA_WIDTH];
  assign prod_lo = prod[DATA_WIDTH-1:0];

  // MULHSU arrives as a signed x signed product. Reinterpreting a negative
  // rs2 as unsigned adds rs1 * 2^W, i.e. rs1 on the high half.
  always_comb begin
    data = prod_lo;
    case (op)
      MUL_U:            data = prod_lo;
      MULH_U, MULHU_U:  data = prod_hi;
      MULHSU_U:         data = prod_hi + (op_b_msb ? op_a : '0);
      default:          data = prod_lo;
    endcase
  end

endmodule

// File: rtl/mul_writeback_stage.sv
// mul_writeback_stage: formats raw Booth multiplier products into RV32M
// results, buffers them in a 2-entry FIFO and hands them to register-file
// writeback with a valid/ready handshake.
// Ports:
//   clk_i         in   clock
//   rst_n_i       in   synchronous active-low reset
//   prod_valid_i  in   product and sideband valid
//   prod_i        in   raw 2*W-bit product
//   op_i          in   op select
//   op_a_i        in   rs1 value (MULHSU correction)
//   op_b_msb_i    in   rs2 sign bit (MULHSU correction)
//   rd_i          in   destination register
//   ready_o       out  stage can accept a product (buffer not full)
//   wb_valid_o    out  writeback result valid
//   wb_ready_i    in   writeback accepts head result
//   wb_data_o     out  formatted result
//   wb_rd_o       out  destination register
//   overflow_o    out  sticky: a product was dropped while full
// Build option: define MUL_WB_BYPASS_EN to forward a product straight to
// writeback in the same cycle when the buffer is empty. Without it the stage
// is fully registered with one cycle of latency.
module mul_writeback_stage
  import mul_writeback_stage_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_WB_DATA_WIDTH,
  parameter int RD_WIDTH   = MUL_WB_RD_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    prod_valid_i,
  input  logic [2*DATA_WIDTH-1:0] prod_i,
  input  mul_ops_e                op_i,
  input  logic [DATA_WIDTH-1:0]   op_a_i,
  input  logic                    op_b_msb_i,
  input  logic [RD_WIDTH-1:0]     rd_i,
  output logic                    ready_o,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [RD_WIDTH-1:0]     wb_rd_o,
  output logic                    overflow_o
);

  logic [DATA_WIDTH-1:0] fmt_data;
  mul_wb_entry_t         entries [MUL_WB_DEPTH];
  mul_wb_entry_t         head;
  fifo_state_e           state;
  fifo_state_e           state_next;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  overflow;
  logic                  fifo_valid;
  logic                  push;
  logic                  pop;
  logic                  drop;

  mul_result_format #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_format (
    .op       (op_i),
    .prod     (prod_i),
    .op_a     (op_a_i),
    .op_b_msb (op_b_msb_i),
    .data     (fmt_data)
  );

  assign head       = entries[rd_ptr];
  assign fifo_valid = (state != FIFO_EMPTY);
  assign ready_o    = (state != FIFO_FULL);
  assign pop        = fifo_valid && wb_ready_i;
  assign drop       = prod_valid_i && !ready_o && !pop;
  assign overflow_o = overflow;

`ifdef MUL_WB_BYPASS_EN
  logic bypass_hit;

  // An empty buffer lets the product through combinationally; it only needs
  // storing if writeback does not take it this cycle.
  assign bypass_hit = (state == FIFO_EMPTY) && prod_valid_i;
  assign wb_valid_o = fifo_valid || bypass_hit;
  assign wb_data_o  = fifo_valid ? head.data : fmt_data;
  assign wb_rd_o    = fifo_valid ? head.rd   : rd_i;
  assign push       = prod_valid_i && (ready_o || pop) && !(bypass_hit && wb_ready_i);
`else
  assign wb_valid_o = fifo_valid;
  assign wb_data_o  = head.data;
  assign wb_rd_o    = head.rd;
  assign push       = prod_valid_i && (ready_o || pop);
`endif

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    state_next = state;
    if (push && !pop) begin
      case (state)
        FIFO_EMPTY: state_next = FIFO_ONE;
        FIFO_ONE:   state_next = FIFO_FULL;
        default:    state_next = state;
      endcase
    end else if (pop && !push) begin
      case (state)
        FIFO_FULL:  state_next = FIFO_ONE;
        FIFO_ONE:   state_next = FIFO_EMPTY;
        default:    state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= FIFO_EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < MUL_WB_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (push) begin
        entries[wr_ptr] <= '{data: fmt_data, rd: rd_i};
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_writeback_stage.sv
// Testbench for mul_writeback_stage. A queue-based reference model predicts
// wb_valid/data/rd, ready and overflow every cycle; directed scenarios add
// hand-computed literal checks. Works with and without MUL_WB_BYPASS_EN.
module tb_mul_writeback_stage;
  import mul_writeback_stage_pkg::*;

`ifdef MUL_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prod_valid = 1'b0;
  logic [63:0] prod = '0;
  mul_ops_e    op = MUL_U;
  logic [31:0] op_a = '0;
  logic        op_b_msb = 1'b0;
  logic [4:0]  rd = '0;
  logic        wb_ready = 1'b0;
  logic        ready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        overflow;

  mul_writeback_stage #(
    .DATA_WIDTH (32),
    .RD_WIDTH   (5)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .prod_valid_i (prod_valid),
    .prod_i       (prod),
    .op_i         (op),
    .op_a_i       (op_a),
    .op_b_msb_i   (op_b_msb),
    .rd_i         (rd),
    .ready_o      (ready),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_data_o    (wb_data),
    .wb_rd_o      (wb_rd),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  bit   ovfModel = 1'b0;
  bit   live = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  int          mN;
  bit          mValid;
  bit          mPop;
  bit          mPush;
  bit          eValid;
  logic [31:0] eData;
  logic [4:0]  eRd;

  // Result as the ISA defines it: low half, high half, or high half of the
  // signed x unsigned product (signed product plus rs1 * 2^32 when rs2 < 0).
  function automatic logic [31:0] refFormat(mul_ops_e o, logic [63:0] p,
                                            logic [31:0] a, logic bm);
    logic [63:0] hi;
    logic [63:0] sum;
    hi  = p >> 32;
    sum = hi + (bm ? {32'h0, a} : 64'h0);
    case (o)
      MUL_U:    return p[31:0];
      MULHSU_U: return sum[31:0];
      default:  return hi[31:0];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: a bounded queue of pending results.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      ovfModel = 1'b0;
      live     = 1'b1;
    end else if (live) begin
      mN     = q.size();
      mValid = (mN > 0) || (BYP && prod_valid);
      mPop   = mValid && wb_ready;
      mPush  = 1'b0;
      if (prod_valid) begin
        if (BYP && mN == 0 && wb_ready) mPush = 1'b0;
        else if (mN < 2 || mPop)        mPush = 1'b1;
        else                            ovfModel = 1'b1;
      end
      if (mPop && mN > 0) void'(q.pop_front());
      if (mPush) q.push_back('{refFormat(op, prod, op_a, op_b_msb), rd});
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      if (q.size() > 0) begin
        eValid = 1'b1;
        eData  = q[0].data;
        eRd    = q[0].rd;
      end else begin
        eValid = BYP && prod_valid;
        eData  = refFormat(op, prod, op_a, op_b_msb);
        eRd    = rd;
      end
      checkOutput("model_wb_valid", wb_valid, eValid);
      checkOutput("model_ready", ready, q.size() < 2);
      checkOutput("model_overflow", overflow, ovfModel);
      if (eValid) begin
        checkOutput("model_wb_data", wb_data, eData);
        checkOutput("model_wb_rd", wb_rd, eRd);
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit v, input mul_ops_e o,
                               input logic [63:0] p, input logic [31:0] a,
                               input logic bm, input logic [4:0] d,
                               input bit wr);
    @(posedge clk);
    #1;
    rst_n      = r;
    prod_valid = v;
    op         = o;
    prod       = p;
    op_a       = a;
    op_b_msb   = bm;
    rd         = d;
    wb_ready   = wr;
    @(negedge clk);
  endtask

  task automatic idle(input bit wr);
    applyStimulus(1'b1, 1'b0, MUL_U, 64'h0, 32'h0, 1'b0, 5'd0, wr);
  endtask

  task automatic pushMul(input logic [4:0] d, input bit wr);
    applyStimulus(1'b1, 1'b1, MUL_U, {32'h0, 27'h8, d}, 32'h0, 1'b0, d, wr);
  endtask

  // One product with writeback always ready: it must appear for exactly one
  // cycle, in N with bypass or N+1 without.
  task automatic runSingle(input string name, input mul_ops_e o,
                           input logic [63:0] p, input logic [31:0] a,
                           input logic bm, input logic [4:0] d,
                           input logic [31:0] expected);
    logic        v0, v1;
    logic [31:0] d0, d1;
    logic [4:0]  r0, r1;
    applyStimulus(1'b1, 1'b1, o, p, a, bm, d, 1'b1);
    v0 = wb_valid; d0 = wb_data; r0 = wb_rd;
    idle(1'b1);
    v1 = wb_valid; d1 = wb_data; r1 = wb_rd;
    checkOutput({name, "_valid_N"}, v0, BYP);
    checkOutput({name, "_valid_N1"}, v1, !BYP);
    checkOutput({name, "_data"}, v0 ? d0 : d1, expected);
    checkOutput({name, "_rd"}, v0 ? r0 : r1, d);
    idle(1'b1);
    checkOutput({name, "_drained"}, wb_valid, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, MUL_U, 64'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, MUL_U, 64'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("reset_wb_valid", wb_valid, 1'b0);
    checkOutput("reset_ready", ready, 1'b1);
    checkOutput("reset_overflow", overflow, 1'b0);
    checkOutput("reset_wb_data", wb_data, 32'h0);
    checkOutput("reset_wb_rd", wb_rd, 5'd0);
    idle(1'b1);

    runSingle("mul",      MUL_U,    64'hFFFFFFFF_FFFFFFFA, 32'h0,        1'b0, 5'd7,  32'hFFFFFFFA);
    runSingle("mulh",     MULH_U,   64'hFFFFFFFF_FFFFFFFA, 32'h0,        1'b0, 5'd9,  32'hFFFFFFFF);
    runSingle("mulhu",    MULHU_U,  64'hFFFFFFFE_00000001, 32'h0,        1'b0, 5'd11, 32'hFFFFFFFE);
    runSingle("mulhsu_n", MULHSU_U, 64'h00000000_00000001, 32'hFFFFFFFF, 1'b1, 5'd13, 32'hFFFFFFFF);
    runSingle("mulhsu_p", MULHSU_U, 64'h00000005_00000000, 32'hFFFFFFFF, 1'b0, 5'd31, 32'h00000005);

    // Back-pressure and overflow.
    pushMul(5'd1, 1'b0);
    pushMul(5'd2, 1'b0);
    idle(1'b0);
    checkOutput("bp_ready_full", ready, 1'b0);
    pushMul(5'd3, 1'b0);
    idle(1'b0);
    checkOutput("bp_overflow", overflow, 1'b1);
    checkOutput("bp_head_rd_stable", wb_rd, 5'd1);
    checkOutput("bp_head_data_stable", wb_data, 32'h101);
    idle(1'b1);
    checkOutput("bp_first_rd", wb_rd, 5'd1);
    idle(1'b1);
    checkOutput("bp_second_rd", wb_rd, 5'd2);
    checkOutput("bp_overflow_sticky", overflow, 1'b1);
    idle(1'b1);
    checkOutput("bp_empty", wb_valid, 1'b0);
    checkOutput("bp_overflow_still", overflow, 1'b1);

    applyStimulus(1'b0, 1'b0, MUL_U, 64'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    idle(1'b0);
    checkOutput("rst2_overflow_clear", overflow, 1'b0);

    // Push into a full buffer while the head is popped.
    pushMul(5'd1, 1'b0);
    pushMul(5'd2, 1'b0);
    pushMul(5'd3, 1'b1);
    checkOutput("pp_head1", wb_rd, 5'd1);
    idle(1'b0);
    checkOutput("pp_still_full", ready, 1'b0);
    checkOutput("pp_head2", wb_rd, 5'd2);
    checkOutput("pp_no_overflow", overflow, 1'b0);
    idle(1'b1);
    checkOutput("pp_rd2", wb_rd, 5'd2);
    idle(1'b1);
    checkOutput("pp_rd3", wb_rd, 5'd3);
    checkOutput("pp_data3", wb_data, 32'h103);
    idle(1'b1);
    checkOutput("pp_empty", wb_valid, 1'b0);

    // Reset with two entries held and overflow set.
    pushMul(5'd4, 1'b0);
    pushMul(5'd5, 1'b0);
    pushMul(5'd6, 1'b0);
    idle(1'b0);
    checkOutput("rst_pre_overflow", overflow, 1'b1);
    applyStimulus(1'b0, 1'b0, MUL_U, 64'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    idle(1'b1);
    checkOutput("rst_flush_valid", wb_valid, 1'b0);
    checkOutput("rst_flush_ready", ready, 1'b1);
    checkOutput("rst_flush_overflow", overflow, 1'b0);
    idle(1'b1);
    checkOutput("rst_flush_no_emit", wb_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
